// File: rtl/config_loader.sv
// Serial configuration-chain loader: takes bitstream words over a valid/ready
// handshake and shifts them LSB first into the cell chain.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, user logic released
// LOAD  | data_ready high, waiting for the next bitstream word
// SHIFT | shifting the captured word into the chain, one bit per cycle
// DONE  | chain fully loaded, bits_loaded frozen until start
module config_loader #(
  parameter int CHAIN_BITS = 650,
  parameter int WORD_WIDTH = 8
) (
  input  logic                              shift_clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [WORD_WIDTH-1:0]             data_in,
  input  logic                              data_valid,
  output logic                              data_ready,
  output logic                              cfg_shift_in,
  output logic                              cfg_shift_enable,
  output logic                              user_reset_hold,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(CHAIN_BITS+1)-1:0]   bits_loaded
);

  localparam int CNT_W = $clog2(CHAIN_BITS + 1);
  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_BITS - 1);
  localparam logic [IDX_W-1:0] WORD_LAST  = IDX_W'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [WORD_WIDTH-1:0]   shift_reg;
  logic [IDX_W-1:0]        bit_idx;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    load_word;
  logic                    shift_bit;
  logic                    clear_cnt;

  always_ff @(posedge shift_clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort wins over a same-cycle handshake or shift, so the word is dropped
  // and the partial count is left untouched.
  always_comb begin
    state_nxt = state;
    load_word = 1'b0;
    shift_bit = 1'b0;
    clear_cnt = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          clear_cnt = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (data_valid) begin
          load_word = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          shift_bit = 1'b1;
          // chain-full check first: a short final word ends the load early
          if (bit_cnt == CHAIN_LAST) begin
            state_nxt = ST_DONE;
          end else if (bit_idx == WORD_LAST) begin
            state_nxt = ST_LOAD;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge shift_clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      bit_cnt   <= '0;
    end else begin
      if (load_word) begin
        shift_reg <= data_in;
        bit_idx   <= '0;
      end else if (shift_bit) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + IDX_W'(1);
      end
      if (clear_cnt) begin
        bit_cnt <= '0;
      end else if (shift_bit) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  assign data_ready       = (state == ST_LOAD);
  assign cfg_shift_enable = (state == ST_SHIFT);
  assign busy             = (state == ST_LOAD) || (state == ST_SHIFT);
  assign user_reset_hold  = busy;
  assign done             = (state == ST_DONE);
  assign cfg_shift_in     = cfg_shift_enable & shift_reg[0];
  assign bits_loaded      = bit_cnt;

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter CHAIN_BITS, default 650, SHALL set the total configuration-chain length in bits (10 cells x 65 bits).
REQ-002 Parameter WORD_WIDTH, default 8, SHALL set the input data word width.
REQ-003 shift_clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a new configuration load; it is sampled only in IDLE or DONE.
REQ-006 abort  input  1  SHALL cancel an in-progress load.
REQ-007 data_in  input  WORD_WIDTH  SHALL carry the next bitstream word.
REQ-008 data_valid  input  1  SHALL qualify data_in.
REQ-009 data_ready  output  1  SHALL indicate the block accepts data_in this cycle.
REQ-010 cfg_shift_in  output  1  SHALL drive the serial data into the cell chain.
REQ-011 cfg_shift_enable  output  1  SHALL drive the chain write/shift enable.
REQ-012 user_reset_hold  output  1  SHALL hold user logic in reset while the chain is being configured.
REQ-013 busy  output  1  SHALL be high in LOAD and SHIFT.
REQ-014 done  output  1  SHALL be high in DONE.
REQ-015 bits_loaded  output  $clog2(CHAIN_BITS+1)  SHALL report the number of bits shifted so far.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT, and DONE.
REQ-017 IDLE or DONE with start=1 SHALL transition to LOAD and clear bits_loaded to 0.
REQ-018 LOAD SHALL assert data_ready=1; a handshake is data_valid & data_ready.
REQ-019 A LOAD handshake SHALL capture data_in into a WORD_WIDTH shift register, clear the in-word bit index, and enter SHIFT on the next cycle.
REQ-020 LOAD without data_valid SHALL remain in LOAD indefinitely, with cfg_shift_enable=0.
REQ-021 SHIFT SHALL assert cfg_shift_enable=1 every cycle.
REQ-022 In SHIFT, cfg_shift_in SHALL equal the shift-register LSB, so words are sent LSB first.
REQ-023 Each SHIFT cycle SHALL shift the shift register right by one, increment the bit index, and increment bits_loaded.
REQ-024 SHIFT SHALL leave for DONE when bits_loaded reaches CHAIN_BITS; this check takes priority over the word-boundary check.
REQ-025 Otherwise, SHIFT SHALL return to LOAD after WORD_WIDTH bits.
REQ-026 When CHAIN_BITS is not a multiple of WORD_WIDTH, the unused high bits of the final word SHALL be discarded and never shifted.
REQ-027 data_ready, cfg_shift_enable, busy and done SHALL be pure decodes of the state register.
REQ-028 cfg_shift_in SHALL be 0 whenever cfg_shift_enable=0.
REQ-029 user_reset_hold SHALL be high in LOAD and SHIFT and low in IDLE and DONE.
REQ-030 done SHALL remain high until start or reset.
REQ-031 bits_loaded SHALL hold its value in DONE.
REQ-032 start while busy SHALL be ignored.
REQ-033 abort in LOAD or SHIFT SHALL force IDLE on the next edge, and bits_loaded SHALL hold its partial count.
REQ-034 abort SHALL take priority over a simultaneous data handshake or bit shift, and the word SHALL be dropped.
REQ-035 abort in IDLE or DONE SHALL have no effect.
REQ-036 start and abort together in IDLE SHALL enter LOAD.
REQ-037 Total cfg_shift_enable cycles per completed load SHALL equal CHAIN_BITS exactly.

Reset
REQ-038 Asserting reset SHALL immediately force IDLE regardless of clock.
REQ-039 During reset, all outputs SHALL read 0: data_ready, cfg_shift_in, cfg_shift_enable, user_reset_hold, busy, done, and bits_loaded.
REQ-040 Reset mid-SHIFT SHALL deassert cfg_shift_enable asynchronously, and no further bits SHALL be shifted.
REQ-041 After reset deassertion, the block SHALL wait in IDLE for start.

Verification
REQ-042 Full load: CHAIN_BITS=650, start, then 82 words with valid always high -> exactly 650 enable pulses, the last word's 6 high bits unused, done=1, bits_loaded=650.
REQ-043 Bit order: word 8'hA5 -> cfg_shift_in sequence 1,0,1,0,0,1,0,1 on 8 consecutive enabled cycles.
REQ-044 Backpressure: valid low for 5 cycles in LOAD -> data_ready stays 1, enable stays 0, and there are no spurious bits.
REQ-045 Abort: abort on the 3rd SHIFT cycle of word 2 -> IDLE next edge, bits_loaded=10, and enable is 0 thereafter.
REQ-046 Reset: async reset pulse mid-SHIFT between clock edges -> all outputs 0 immediately, and a restart loads all 650 bits correctly.
REQ-047 Restart: start in DONE -> done drops, bits_loaded=0, and data_ready=1 next cycle.
